muldiv_sequencer: RTL and testbench

//  Sequences the shared iterative multiply/divide engine for the multicycle core.
//  The main control FSM pulses start in its MULT/DIV state; this block runs the

---
 rtl/muldiv_sequencer.sv | 92 +++++++++
 tb/tb_muldiv_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: steps the shared multiply/divide engine through load, WIDTH iterations, optional sign fix and HI/LO write.
// Define MULDIV_SIGNFIX_EN to route DIV through the FIX state; otherwise eng_fix is tied low.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mult_or_div,
    input  logic             divisor_zero,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic             eng_sel,
    output logic             eng_load,
    output logic             eng_step,
    output logic             eng_fix,
    output logic             hi_write,
    output logic             lo_write,
    output logic [CNT_W-1:0] iter_count
);
    typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, WRITE, ERR} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`ifdef MULDIV_SIGNFIX_EN
    localparam logic FIX_EN = 1'b1;
    logic fix_q;
`else
    localparam logic FIX_EN = 1'b0;
`endif
    state_t state, nxt;
    logic load_q, step_q, write_q, err_q, busy_q;

    always_comb begin
        nxt = IDLE;
        if (!flush)
            unique case (state)
                IDLE:    nxt = start ? ((mult_or_div && divisor_zero) ? ERR : LOAD) : IDLE;
                LOAD:    nxt = ITER;
                ITER:    nxt = (iter_count == LAST) ? ((FIX_EN && eng_sel) ? FIX : WRITE) : ITER;
                FIX:     nxt = WRITE;
                default: nxt = IDLE;
            endcase
    end

    // Strobe flags are registered from the next state so each output is a flop masked only by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            iter_count <= '0;
            eng_sel    <= 1'b0;
            load_q     <= 1'b0;
            step_q     <= 1'b0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef MULDIV_SIGNFIX_EN
            fix_q      <= 1'b0;
`endif
        end else begin
            state   <= nxt;
            load_q  <= nxt == LOAD;
            step_q  <= nxt == ITER;
            write_q <= nxt == WRITE;
            err_q   <= nxt == ERR;
            busy_q  <= nxt != IDLE;
`ifdef MULDIV_SIGNFIX_EN
            fix_q   <= nxt == FIX;
`endif
            if (state == IDLE && start && !flush)
                eng_sel <= mult_or_div;
            if (flush || state == LOAD)
                iter_count <= '0;
            else if (state == ITER)
                iter_count <= (iter_count == LAST) ? '0 : iter_count + CNT_W'(1);
        end
    end

    assign busy     = busy_q;
    assign done     = write_q & ~flush;
    assign hi_write = write_q & ~flush;
    assign lo_write = write_q & ~flush;
    assign div0     = err_q & ~flush;
    assign eng_load = load_q & ~flush;
    assign eng_step = step_q & ~flush;
`ifdef MULDIV_SIGNFIX_EN
    assign eng_fix  = fix_q & ~flush;
`else
    assign eng_fix  = 1'b0;
`endif
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed scenarios for muldiv_sequencer with hand-derived cycle expectations.
module tb_muldiv_sequencer;
    logic       clk = 1'b0, reset = 1'b1;
    logic       start = 1'b0, mult_or_div = 1'b0, divisor_zero = 1'b0, flush = 1'b0;
    logic       busy, done, div0, eng_sel, eng_load, eng_step, eng_fix, hi_write, lo_write;
    logic [5:0] iter_count;
    int         compared = 0, mismatched = 0;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .mult_or_div(mult_or_div),
        .divisor_zero(divisor_zero), .flush(flush), .busy(busy), .done(done),
        .div0(div0), .eng_sel(eng_sel), .eng_load(eng_load), .eng_step(eng_step),
        .eng_fix(eng_fix), .hi_write(hi_write), .lo_write(lo_write), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    // Outputs packed as {busy,done,div0,eng_load,eng_step,eng_fix,hi_write,lo_write}.
    function automatic logic [7:0] outs();
        return {busy, done, div0, eng_load, eng_step, eng_fix, hi_write, lo_write};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        compared++;
        if ({outs(), eng_sel, iter_count} !== 15'd0) begin
            mismatched++;
            $display("FAIL reset_state got outs=%b sel=%b iter=%0d want all 0", outs(), eng_sel, iter_count);
        end
        reset = 1'b0;
        tick();
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_mult();
        logic [7:0] exp;
        start = 1'b1; mult_or_div = 1'b0; divisor_zero = 1'b0;
        tick();
        start = 1'b0;
        compared++;
        if (eng_sel !== 1'b0) begin
            mismatched++;
            $display("FAIL mult_sel got %b want 0", eng_sel);
        end
        for (int c = 1; c <= 36; c++) begin
            exp = {c >= 1 && c <= 34, c == 34, 1'b0, c == 1, c >= 2 && c <= 33, 1'b0, c == 34, c == 34};
            compared++;
            if (outs() !== exp) begin
                mismatched++;
                $display("FAIL mult_cycle%0d got %b want %b", c, outs(), exp);
            end
            if (c >= 2 && c <= 33) begin
                compared++;
                if (iter_count !== 6'(c - 2)) begin
                    mismatched++;
                    $display("FAIL mult_iter cyc%0d got %0d want %0d", c, iter_count, c - 2);
                end
            end
            tick();
        end
    endtask

    task automatic test_div0();
        start = 1'b1; mult_or_div = 1'b1; divisor_zero = 1'b1;
        tick();
        start = 1'b0; divisor_zero = 1'b0;
        compared++;
        if ({outs(), eng_sel} !== 9'b1_0_1_0_0_0_0_0_1) begin
            mismatched++;
            $display("FAIL div0_cycle1 got outs=%b sel=%b want 10100000 sel=1", outs(), eng_sel);
        end
        tick();
        compared++;
        if (outs() !== 8'd0) begin
            mismatched++;
            $display("FAIL div0_cycle2 got %b want 00000000", outs());
        end
    endtask

    task automatic test_div();
        logic [7:0] exp;
        int         dc;
        int         fc;
`ifdef MULDIV_SIGNFIX_EN
        dc = 35; fc = 34;
`else
        dc = 34; fc = -1;
`endif
        start = 1'b1; mult_or_div = 1'b1; divisor_zero = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 37; c++) begin
            exp = {c >= 1 && c <= dc, c == dc, 1'b0, c == 1, c >= 2 && c <= 33, c == fc, c == dc, c == dc};
            compared++;
            if (outs() !== exp) begin
                mismatched++;
                $display("FAIL div_cycle%0d got %b want %b", c, outs(), exp);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        int writes = 0;
        start = 1'b1; mult_or_div = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 1; c < 12; c++) tick();
        compared++;
        if (iter_count !== 6'd10 || eng_step !== 1'b1) begin
            mismatched++;
            $display("FAIL flush_pre got iter=%0d step=%b want iter=10 step=1", iter_count, eng_step);
        end
        flush = 1'b1;
        #1;
        compared++;
        if (outs() !== 8'b1000_0000) begin
            mismatched++;
            $display("FAIL flush_mask got %b want 10000000", outs());
        end
        tick();
        flush = 1'b0;
        compared++;
        if (busy !== 1'b0 || iter_count !== 6'd0) begin
            mismatched++;
            $display("FAIL flush_idle got busy=%b iter=%0d want 0/0", busy, iter_count);
        end
        for (int c = 0; c < 40; c++) begin
            writes += int'(done) + int'(hi_write) + int'(eng_step);
            tick();
        end
        compared++;
        if (writes !== 0) begin
            mismatched++;
            $display("FAIL flush_after got %0d strobes want 0", writes);
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        start = 1'b1; mult_or_div = 1'b0;
        tick();
        for (int c = 1; c <= 36; c++) begin
            start = (c == 5 || c == 34 || c == 35);
            #1;
            if (c <= 35) dones += int'(done);
            if (c == 35) begin
                compared++;
                if (busy !== 1'b0) begin
                    mismatched++;
                    $display("FAIL b2b_idle35 busy got %b want 0", busy);
                end
            end
            if (c == 36) begin
                compared++;
                if (eng_load !== 1'b1) begin
                    mismatched++;
                    $display("FAIL b2b_load36 got %b want 1", eng_load);
                end
            end
            tick();
        end
        start = 1'b0;
        compared++;
        if (dones !== 1) begin
            mismatched++;
            $display("FAIL b2b_dones got %0d want 1", dones);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        start = 1'b1; mult_or_div = 1'b1; divisor_zero = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        compared++;
        if (eng_step !== 1'b1 || eng_sel !== 1'b1) begin
            mismatched++;
            $display("FAIL rstmid_pre got step=%b sel=%b want 1/1", eng_step, eng_sel);
        end
        reset = 1'b1;
        #1;
        compared++;
        if ({outs(), eng_sel, iter_count} !== 15'd0) begin
            mismatched++;
            $display("FAIL rstmid_async got outs=%b sel=%b iter=%0d want all 0", outs(), eng_sel, iter_count);
        end
        tick();
        reset = 1'b0;
        tick();
        compared++;
        if ({busy, eng_sel, iter_count} !== 8'd0) begin
            mismatched++;
            $display("FAIL rstmid_after got busy=%b sel=%b iter=%0d want 0", busy, eng_sel, iter_count);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div0();
        test_div();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
